// File: rtl/fp_pkg.sv
// Shared single-precision constants for the FP adder and its sharing controller.
package fp_pkg;
  localparam int unsigned FP_W = 32;
  localparam int unsigned RM_W = 2;

  localparam logic [RM_W-1:0] RM_NEAREST = 2'b00;
  localparam logic [RM_W-1:0] RM_DOWN    = 2'b01;
  localparam logic [RM_W-1:0] RM_UP      = 2'b10;
  localparam logic [RM_W-1:0] RM_ZERO    = 2'b11;

  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;
  localparam logic [FP_W-1:0] FP_MAX     = 32'h7F7FFFFF;
  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;
endpackage

// File: rtl/fadd_share_ctrl_if.sv
// Request/response bundle between FP issue clients and the shared adder controller.
interface fadd_share_ctrl_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  import fp_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      req_sub;
  logic [NREQ*RM_W-1:0] req_rm;
  logic                 res_valid;
  logic                 res_ready;
  logic [FP_W-1:0]      res_s;
  logic [IDW-1:0]       res_id;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_rm, res_ready,
    input  req_ready, res_valid, res_s, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_rm, res_ready,
    output req_ready, res_valid, res_s, res_id, busy
  );
endinterface

// File: rtl/fadder.sv
// Combinational IEEE single-precision adder/subtractor with four rounding modes.
module fadder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  input  logic [RM_W-1:0] rm,
  output logic [FP_W-1:0] s
);
  logic        w_sa, w_sb, w_sx, w_sy, w_inc;
  logic        w_nan, w_inf_a, w_inf_b;
  logic [30:0] w_x, w_y;
  logic [7:0]  w_ex, w_ey, w_d;
  logic [23:0] w_mx, w_my;
  logic [26:0] w_ye, w_ys, w_mask, w_n;
  logic [27:0] w_sum;
  logic [9:0]  w_e;
  logic [24:0] w_mr;

  always_comb begin
    w_sa    = a[31];
    w_sb    = b[31] ^ sub;
    w_inf_a = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    w_inf_b = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    w_nan   = ((a[30:23] == 8'hFF) && (a[22:0] != '0)) ||
              ((b[30:23] == 8'hFF) && (b[22:0] != '0)) ||
              (w_inf_a && w_inf_b && (w_sa != w_sb));

    // x is the larger magnitude; the result sign follows it
    if (a[30:0] >= b[30:0]) begin
      w_x = a[30:0]; w_sx = w_sa; w_y = b[30:0]; w_sy = w_sb;
    end else begin
      w_x = b[30:0]; w_sx = w_sb; w_y = a[30:0]; w_sy = w_sa;
    end
    w_ex = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
    w_ey = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
    w_mx = {w_x[30:23] != 8'd0, w_x[22:0]};
    w_my = {w_y[30:23] != 8'd0, w_y[22:0]};
    w_d  = w_ex - w_ey;

    // align with guard/round/sticky bits
    w_ye   = {w_my, 3'b000};
    w_mask = '0;
    if (w_d >= 8'd27) begin
      w_ys = {26'd0, |w_my};
    end else begin
      w_mask = (27'd1 << w_d) - 27'd1;
      w_ys   = (w_ye >> w_d) | {26'd0, |(w_ye & w_mask)};
    end

    if (w_sx == w_sy) w_sum = {1'b0, w_mx, 3'b000} + {1'b0, w_ys};
    else              w_sum = {1'b0, w_mx, 3'b000} - {1'b0, w_ys};

    w_e = {2'b00, w_ex};
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e = w_e + 10'd1;
    end else begin
      // left-normalise, stopping at the minimum exponent to produce subnormals
      w_n = w_sum[26:0];
      for (int unsigned i = 0; i < 26; i++) begin
        if (!w_n[26] && (w_e > 10'd1)) begin
          w_n = w_n << 1;
          w_e = w_e - 10'd1;
        end
      end
    end

    unique case (rm)
      RM_NEAREST: w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      RM_DOWN:    w_inc = w_sx & (w_n[2] | w_n[1] | w_n[0]);
      RM_UP:      w_inc = ~w_sx & (w_n[2] | w_n[1] | w_n[0]);
      default:    w_inc = 1'b0;
    endcase
    w_mr = {1'b0, w_n[26:3]} + {24'd0, w_inc};
    if (w_mr[24]) begin
      w_mr = {1'b0, w_mr[24:1]};
      w_e  = w_e + 10'd1;
    end

    if (w_nan)                s = FP_QNAN;
    else if (w_inf_a)         s = {w_sa, FP_POS_INF[30:0]};
    else if (w_inf_b)         s = {w_sb, FP_POS_INF[30:0]};
    else if (w_sum == '0)     s = {(w_sx == w_sy) ? w_sx : (rm == RM_DOWN), 31'd0};
    else if (w_e >= 10'd255) begin
      if ((rm == RM_ZERO) || ((rm == RM_DOWN) && !w_sx) || ((rm == RM_UP) && w_sx))
        s = {w_sx, FP_MAX[30:0]};
      else
        s = {w_sx, FP_POS_INF[30:0]};
    end
    else if (!w_mr[23])       s = {w_sx, 8'd0, w_mr[22:0]};
    else                      s = {w_sx, w_e[7:0], w_mr[22:0]};
  end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps NREQ-1 -> 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid
);
  logic [IDW:0] w_idx;
  logic         w_found;

  always_comb begin
    grant   = '0;
    gid     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (en && !w_found && req[w_idx[IDW-1:0]]) begin
        grant[w_idx[IDW-1:0]] = 1'b1;
        gid                   = w_idx[IDW-1:0];
        w_found               = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one fadder among NREQ clients: round-robin grant, operand stage, result stage
// with a tagged valid/ready response channel.
module fadd_share_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input logic              clk,
  input logic              rst,
  fadd_share_ctrl_if.slave bus
);
  logic            r_s1_valid;
  logic [FP_W-1:0] r_s1_a;
  logic [FP_W-1:0] r_s1_b;
  logic            r_s1_sub;
  logic [RM_W-1:0] r_s1_rm;
  logic [IDW-1:0]  r_s1_id;
  logic            r_res_valid;
  logic [FP_W-1:0] r_res_s;
  logic [IDW-1:0]  r_res_id;
  logic [IDW-1:0]  r_ptr;

  logic            w_s2_free;
  logic            w_s1_adv;
  logic            w_s1_free;
  logic            w_arb_en;
  logic            w_accept;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [FP_W-1:0] w_fadd_s;

  assign w_s2_free = ~r_res_valid | bus.res_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_free;
  assign w_s1_free = ~r_s1_valid | w_s1_adv;
  assign w_arb_en  = w_s1_free & ~rst;
  assign w_accept  = |w_grant;
  assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (r_ptr),
    .en    (w_arb_en),
    .grant (w_grant),
    .gid   (w_gid)
  );

  fadder u_fadd (
    .a   (r_s1_a),
    .b   (r_s1_b),
    .sub (r_s1_sub),
    .rm  (r_s1_rm),
    .s   (w_fadd_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // accept takes priority: a move to s2 and a new load can share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= bus.req_a[w_gid*FP_W +: FP_W];
      r_s1_b     <= bus.req_b[w_gid*FP_W +: FP_W];
      r_s1_sub   <= bus.req_sub[w_gid];
      r_s1_rm    <= bus.req_rm[w_gid*RM_W +: RM_W];
      r_s1_id    <= w_gid;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_s     <= '0;
      r_res_id    <= '0;
    end else if (w_s1_adv) begin
      r_res_valid <= 1'b1;
      r_res_s     <= w_fadd_s;
      r_res_id    <= r_s1_id;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.res_valid = r_res_valid;
  assign bus.res_s     = r_res_s;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = r_s1_valid | r_res_valid;
endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Scoreboard bench for fadd_share_ctrl: expected results queued at accept, checked at retire.
module tb_fadd_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [31:0]    s;
    logic [IDW-1:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fadd_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fadd_share_ctrl #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_s [NREQ];
  logic [31:0] ovf_exp [4];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // handshakes are sampled on the falling edge, where all inputs are settled
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check_eq("res_unexpected", 32'(bus.res_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check_eq("res_s", bus.res_s, e.s);
          check_eq("res_id", 32'(bus.res_id), 32'(e.id));
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{s: exp_s[i], id: IDW'(i)});
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [1:0] rm, input logic [31:0] e);
    bus.req_a[32*r +: 32] = a;
    bus.req_b[32*r +: 32] = b;
    bus.req_sub[r]        = sub;
    bus.req_rm[2*r +: 2]  = rm;
    exp_s[r]              = e;
    bus.req_valid[r]      = 1'b1;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [1:0] rm, input logic [31:0] e);
    logic got;
    got = 1'b0;
    set_req(r, a, b, sub, rm, e);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.req_ready[r];
      drive_edge();
    end
    bus.req_valid[r] = 1'b0;
    check_eq("issue_grant", 32'(got), 32'h1);
  endtask

  task automatic drain();
    logic [NREQ-1:0] acc;
    logic            done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      acc  = bus.req_valid & bus.req_ready;
      done = (sb.size() == 0) && !bus.busy && (bus.req_valid == '0);
      drive_edge();
      bus.req_valid = bus.req_valid & ~acc;
    end
    check_eq("drain_done", 32'(done), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] acc;
    ovf_exp[0] = 32'h7F800000;
    ovf_exp[1] = 32'h7F7FFFFF;
    ovf_exp[2] = 32'h7F800000;
    ovf_exp[3] = 32'h7F7FFFFF;
    for (int i = 0; i < NREQ; i++) exp_s[i] = '0;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.req_rm    = '0;
    bus.res_ready = 1'b1;

    @(negedge clk);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check_eq("rst_res_s", bus.res_s, 32'h0);
    check_eq("rst_res_id", 32'(bus.res_id), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    drive_edge();
    rst           = 1'b0;
    bus.req_valid = '0;

    // basic add plus latency from the accept edge
    issue(0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000);
    @(negedge clk);
    check_eq("lat_s1", 32'(bus.res_valid), 32'h0);
    drive_edge();
    @(negedge clk);
    check_eq("lat_s2", 32'(bus.res_valid), 32'h1);
    drive_edge();

    issue(1, 32'h40400000, 32'h3F800000, 1'b1, 2'b00, 32'h40000000);
    issue(2, 32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000);
    for (int m = 0; m < 4; m++)
      issue(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'(m), ovf_exp[m]);
    drain();

    // fairness: all four held valid, one accept per cycle, no bubbles
    do_reset();
    bus.res_ready = 1'b1;
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000);
    set_req(1, 32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000);
    set_req(2, 32'h3F800000, 32'h40400000, 1'b0, 2'b00, 32'h40800000);
    set_req(3, 32'h3F800000, 32'h40800000, 1'b0, 2'b00, 32'h40A00000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k >= 2) check_eq("rr_no_bubble", 32'(bus.res_valid), 32'h1);
      drive_edge();
    end
    bus.req_valid = '0;
    drain();

    // backpressure: two ops in flight, response held stable
    bus.res_ready = 1'b0;
    set_req(0, 32'h40000000, 32'h40000000, 1'b0, 2'b00, 32'h40800000);
    set_req(1, 32'h40800000, 32'h3F800000, 1'b1, 2'b00, 32'h40400000);
    set_req(2, 32'h3F800000, 32'hBF800000, 1'b0, 2'b00, 32'h00000000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      check_eq("bp_grant", 32'(|bus.req_ready), 32'h1);
      drive_edge();
      bus.req_valid = bus.req_valid & ~acc;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'h0);
      check_eq("bp_res_valid", 32'(bus.res_valid), 32'h1);
      check_eq("bp_sb_depth", 32'(sb.size()), 32'h2);
      if (sb.size() > 0) begin
        check_eq("bp_res_s_hold", bus.res_s, sb[0].s);
        check_eq("bp_res_id_hold", 32'(bus.res_id), 32'(sb[0].id));
      end
      drive_edge();
    end
    bus.res_ready = 1'b1;
    drain();

    // reset with two ops in flight
    do_reset();
    bus.res_ready = 1'b0;
    set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000);
    set_req(1, 32'h40400000, 32'h40400000, 1'b0, 2'b00, 32'h40C00000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      check_eq("mo_grant", 32'(bus.req_ready), 32'(1 << k));
      drive_edge();
      bus.req_valid = bus.req_valid & ~acc;
    end
    @(negedge clk);
    check_eq("mo_busy", 32'(bus.busy), 32'h1);
    check_eq("mo_res_valid", 32'(bus.res_valid), 32'h1);
    drive_edge();
    set_req(1, 32'h40000000, 32'h40400000, 1'b0, 2'b00, 32'h40A00000);
    set_req(3, 32'h40A00000, 32'h40000000, 1'b1, 2'b00, 32'h40400000);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_gate_ready", 32'(bus.req_ready), 32'h0);
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mo_res_valid_clr", 32'(bus.res_valid), 32'h0);
    check_eq("mo_busy_clr", 32'(bus.busy), 32'h0);
    check_eq("mo_ptr_zero", 32'(bus.req_ready), 32'h2);
    drive_edge();
    bus.req_valid[1] = 1'b0;
    bus.res_ready    = 1'b1;
    drain();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("idle_no_stale", 32'(bus.res_valid), 32'h0);
      drive_edge();
    end

    check_eq("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
